// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer for the MIPS datapath: steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB, handshakes with DM and counts retirements.
module mc_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_we,
    output logic             ab_we,
    output logic             pc_we,
    output logic             reg_we,
    output logic             mem_req,
    output logic             mem_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src,
    output logic             ext_op,
    output logic [3:0]       alu_op,
    output logic [2:0]       npc_op,
    output logic [2:0]       state,
    output logic             halted,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_e           state_q, state_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             halted_q, halted_d;
    logic [1:0]       fault_q, fault_d;

    logic is_r, is_nop, is_addu, is_subu, is_jr, is_ori, is_lui;
    logic is_lw, is_sw, is_beq, is_jal, is_legal;

    assign is_r     = (op == 6'b000000);
    assign is_nop   = is_r && (func == 6'b000000);
    assign is_addu  = is_r && (func == 6'b100001);
    assign is_subu  = is_r && (func == 6'b100011);
    assign is_jr    = is_r && (func == 6'b001000);
    assign is_ori   = (op == 6'b001101);
    assign is_lui   = (op == 6'b001111);
    assign is_lw    = (op == 6'b100011);
    assign is_sw    = (op == 6'b101011);
    assign is_beq   = (op == 6'b000100);
    assign is_jal   = (op == 6'b000011);
    assign is_legal = is_nop | is_addu | is_subu | is_jr | is_ori | is_lui |
                      is_lw | is_sw | is_beq | is_jal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            tmo_q     <= '0;
            retired_q <= '0;
            halted_q  <= 1'b0;
            fault_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            retired_q <= retired_d;
            halted_q  <= halted_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        halted_d   = halted_q;
        fault_d    = fault_q;
        ir_we      = 1'b0;
        ab_we      = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src    = 1'b0;
        ext_op     = 1'b0;
        alu_op     = 4'd0;
        npc_op     = 3'd0;
        unique case (state_q)
            S_FETCH: begin
                ir_we   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ab_we = 1'b1;
                if (is_nop) begin
                    pc_we   = 1'b1;
                    state_d = S_FETCH;
                end else if (is_jr) begin
                    pc_we   = 1'b1;
                    npc_op  = 3'd3;
                    state_d = S_FETCH;
                end else if (is_jal) begin
                    state_d = S_WB;
                end else if (!is_legal) begin
                    fault_d  = 2'b01;
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src = is_ori | is_lui | is_lw | is_sw;
                ext_op  = is_lw | is_sw | is_beq;
                if (is_subu)     alu_op = 4'd1;
                else if (is_ori) alu_op = 4'd2;
                else if (is_lui) alu_op = 4'd3;
                else if (is_beq) alu_op = 4'd4;
                else             alu_op = 4'd0;
                if (is_beq) begin
                    pc_we   = 1'b1;
                    npc_op  = zero ? 3'd1 : 3'd0;
                    state_d = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_sw;
                if (mem_ready) begin
                    tmo_d = '0;
                    if (is_sw) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if ((MEM_TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
                    // The current wait cycle is the MEM_TIMEOUT-th without ready.
                    tmo_d    = '0;
                    fault_d  = 2'b10;
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                pc_we      = 1'b1;
                reg_dst    = is_jal ? 2'b10 : (is_r ? 2'b01 : 2'b00);
                mem_to_reg = is_lw ? 2'b01 : (is_jal ? 2'b10 : 2'b00);
                npc_op     = is_jal ? 3'd2 : 3'd0;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        // Reset asynchronously silences every enable and select.
        if (!rst) begin
            ir_we      = 1'b0;
            ab_we      = 1'b0;
            pc_we      = 1'b0;
            reg_we     = 1'b0;
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            reg_dst    = 2'b00;
            mem_to_reg = 2'b00;
            alu_src    = 1'b0;
            ext_op     = 1'b0;
            alu_op     = 4'd0;
            npc_op     = 3'd0;
        end
        retired_d = retired_q + CNT_W'(pc_we);
    end

    assign state      = state_q;
    assign halted     = halted_q;
    assign fault_code = fault_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed scenarios plus randomized instruction streams
// checked against a per-instruction timing/select model.
module tb_mc_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] op = 6'd0, func = 6'd0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       ir_we, ab_we, pc_we, reg_we, mem_req, mem_we, alu_src, ext_op, halted;
    logic [1:0] reg_dst, mem_to_reg, fault_code;
    logic [3:0] alu_op;
    logic [2:0] npc_op, state;
    logic [3:0] retired;

    mc_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
        .ir_we(ir_we), .ab_we(ab_we), .pc_we(pc_we), .reg_we(reg_we),
        .mem_req(mem_req), .mem_we(mem_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src(alu_src), .ext_op(ext_op), .alu_op(alu_op), .npc_op(npc_op),
        .state(state), .halted(halted), .fault_code(fault_code), .retired(retired)
    );

    always #5 clk = ~clk;

    localparam int K_NOP = 0, K_ADDU = 1, K_SUBU = 2, K_JR = 3, K_ORI = 4;
    localparam int K_LUI = 5, K_LW = 6, K_SW = 7, K_BEQ = 8, K_JAL = 9;

    int errors = 0;
    int checks = 0;
    int exp_ret = 0;

    int cyc, n_pcwe, n_regwe, n_memreq, n_memwe, n_irwe;
    logic [2:0] trace [0:63];
    logic [1:0] cap_dst, cap_m2r;
    logic [2:0] cap_npc;
    logic [3:0] cap_alu;
    logic       cap_src, cap_ext, cap_wb_ext;

    // ---------------- reference model (instruction-level rules) ----------------
    function automatic logic [11:0] enc(input int k);
        case (k)
            K_NOP:   return {6'b000000, 6'b000000};
            K_ADDU:  return {6'b000000, 6'b100001};
            K_SUBU:  return {6'b000000, 6'b100011};
            K_JR:    return {6'b000000, 6'b001000};
            K_ORI:   return {6'b001101, 6'($urandom)};
            K_LUI:   return {6'b001111, 6'($urandom)};
            K_LW:    return {6'b100011, 6'($urandom)};
            K_SW:    return {6'b101011, 6'($urandom)};
            K_BEQ:   return {6'b000100, 6'($urandom)};
            default: return {6'b000011, 6'($urandom)};
        endcase
    endfunction

    function automatic int m_cpi(input int k, input int w);
        case (k)
            K_NOP, K_JR:  return 2;
            K_JAL, K_BEQ: return 3;
            K_SW:         return 4 + w;
            K_LW:         return 5 + w;
            default:      return 4;
        endcase
    endfunction

    function automatic bit m_writes(input int k);
        return (k == K_ADDU || k == K_SUBU || k == K_ORI || k == K_LUI || k == K_LW || k == K_JAL);
    endfunction

    function automatic logic [3:0] m_wbsel(input int k);
        logic [1:0] d, m;
        d = (k == K_JAL) ? 2'b10 : ((k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00);
        m = (k == K_LW) ? 2'b01 : ((k == K_JAL) ? 2'b10 : 2'b00);
        return {d, m};
    endfunction

    function automatic logic [2:0] m_npc(input int k, input logic z);
        case (k)
            K_JR:    return 3'd3;
            K_JAL:   return 3'd2;
            K_BEQ:   return z ? 3'd1 : 3'd0;
            default: return 3'd0;
        endcase
    endfunction

    // {alu_op, alu_src, ext_op}
    function automatic logic [5:0] m_exec(input int k);
        case (k)
            K_SUBU:     return {4'd1, 1'b0, 1'b0};
            K_ORI:      return {4'd2, 1'b1, 1'b0};
            K_LUI:      return {4'd3, 1'b1, 1'b0};
            K_LW, K_SW: return {4'd0, 1'b1, 1'b1};
            K_BEQ:      return {4'd4, 1'b0, 1'b1};
            default:    return {4'd0, 1'b0, 1'b0};
        endcase
    endfunction

    // Drives one instruction from its FETCH cycle until the next FETCH or HALT.
    // mem_ready is random outside MEM and asserted on the (w+1)-th MEM cycle.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z, input int w);
        int mcnt;
        mcnt = 0;
        op = o; func = f; zero = z;
        cyc = 0; n_pcwe = 0; n_regwe = 0; n_memreq = 0; n_memwe = 0; n_irwe = 0;
        cap_dst = 2'bxx; cap_m2r = 2'bxx; cap_npc = 3'bxxx; cap_alu = 4'bxxxx;
        cap_src = 1'bx; cap_ext = 1'bx; cap_wb_ext = 1'bx;
        forever begin
            if (state == 3'd3) begin
                mem_ready = (mcnt == w);
                mcnt++;
            end else begin
                mem_ready = 1'($urandom);
            end
            #1;
            trace[cyc] = state;
            n_pcwe += int'(pc_we); n_regwe += int'(reg_we); n_irwe += int'(ir_we);
            n_memreq += int'(mem_req); n_memwe += int'(mem_we);
            if (pc_we) cap_npc = npc_op;
            if (reg_we) begin cap_dst = reg_dst; cap_m2r = mem_to_reg; cap_wb_ext = ext_op; end
            if (state == 3'd2) begin cap_alu = alu_op; cap_src = alu_src; cap_ext = ext_op; end
            cyc++;
            @(negedge clk);
            if (state == 3'd0 || state == 3'd5 || cyc >= 40) break;
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if ({retired, halted, fault_code} !== 7'd0) begin errors++;
            $display("FAIL reset_regs retired=%0d halted=%b fault=%b exp all 0", retired, halted, fault_code); end
        checks++; if ({ir_we, ab_we, pc_we, reg_we, mem_req, mem_we} !== 6'd0) begin errors++;
            $display("FAIL reset_enables got=%b exp=000000", {ir_we, ab_we, pc_we, reg_we, mem_req, mem_we}); end
        checks++; if ({reg_dst, mem_to_reg, alu_src, ext_op, alu_op, npc_op} !== 13'd0) begin errors++;
            $display("FAIL reset_selects got=%b exp=0", {reg_dst, mem_to_reg, alu_src, ext_op, alu_op, npc_op}); end
        @(negedge clk);
        rst = 1'b1;
        exp_ret = 0;
    endtask

    task automatic test_ori;
        run_instr(6'b001101, 6'b110100, 1'b0, 0);
        exp_ret = (exp_ret + 1) % 16;
        checks++; if (cyc !== 4) begin errors++; $display("FAIL ori_cycles got=%0d exp=4", cyc); end
        checks++; if ({trace[0], trace[1], trace[2], trace[3], state} !== {3'd0, 3'd1, 3'd2, 3'd4, 3'd0}) begin errors++;
            $display("FAIL ori_trace got=%0d,%0d,%0d,%0d,%0d exp=0,1,2,4,0", trace[0], trace[1], trace[2], trace[3], state); end
        checks++; if ({4'(n_regwe), cap_dst, cap_wb_ext} !== {4'd1, 2'b00, 1'b0}) begin errors++;
            $display("FAIL ori_wb regwe=%0d dst=%b ext=%b exp 1,00,0", n_regwe, cap_dst, cap_wb_ext); end
        checks++; if ({cap_alu, cap_src, cap_ext} !== {4'd2, 1'b1, 1'b0}) begin errors++;
            $display("FAIL ori_exec alu=%0d src=%b ext=%b exp 2,1,0", cap_alu, cap_src, cap_ext); end
        checks++; if (retired !== 4'(exp_ret)) begin errors++; $display("FAIL ori_retired got=%0d exp=%0d", retired, exp_ret); end
    endtask

    task automatic test_beq;
        for (int i = 0; i < 2; i++) begin
            run_instr(6'b000100, 6'd0, (i == 0), 0);
            exp_ret = (exp_ret + 1) % 16;
            checks++; if (cyc !== 3) begin errors++; $display("FAIL beq%0d_cycles got=%0d exp=3", i, cyc); end
            checks++; if (cap_npc !== ((i == 0) ? 3'd1 : 3'd0)) begin errors++;
                $display("FAIL beq%0d_npc got=%0d exp=%0d", i, cap_npc, (i == 0) ? 1 : 0); end
            checks++; if (n_regwe !== 0) begin errors++; $display("FAIL beq%0d_regwe got=%0d exp=0", i, n_regwe); end
        end
        checks++; if (retired !== 4'(exp_ret)) begin errors++; $display("FAIL beq_retired got=%0d exp=%0d", retired, exp_ret); end
    endtask

    task automatic test_lw;
        run_instr(6'b100011, 6'd0, 1'b0, 3);
        exp_ret = (exp_ret + 1) % 16;
        checks++; if (cyc !== 8) begin errors++; $display("FAIL lw_cycles got=%0d exp=8", cyc); end
        checks++; if ({4'(n_memreq), 4'(n_memwe)} !== {4'd4, 4'd0}) begin errors++;
            $display("FAIL lw_mem req=%0d we=%0d exp 4,0", n_memreq, n_memwe); end
        checks++; if (cap_m2r !== 2'b01) begin errors++; $display("FAIL lw_m2r got=%b exp=01", cap_m2r); end
        checks++; if (retired !== 4'(exp_ret)) begin errors++; $display("FAIL lw_retired got=%0d exp=%0d", retired, exp_ret); end
    endtask

    task automatic test_illegal;
        run_instr(6'b111111, 6'd0, 1'b0, 0);
        checks++; if ({state, halted, fault_code} !== {3'd5, 1'b1, 2'b01}) begin errors++;
            $display("FAIL illegal_halt state=%0d halted=%b fault=%b exp 5,1,01", state, halted, fault_code); end
        checks++; if (cyc !== 2) begin errors++; $display("FAIL illegal_cycles got=%0d exp=2", cyc); end
        checks++; if (retired !== 4'(exp_ret)) begin errors++; $display("FAIL illegal_retired got=%0d exp=%0d", retired, exp_ret); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if ({state, retired, halted, fault_code} !== 10'd0) begin errors++;
            $display("FAIL illegal_reset state=%0d retired=%0d halted=%b fault=%b exp all 0", state, retired, halted, fault_code); end
        @(negedge clk);
        rst = 1'b1;
        exp_ret = 0;
    endtask

    task automatic test_jal_jr;
        int start;
        start = exp_ret;
        run_instr(6'b000011, 6'b010101, 1'b0, 0);
        checks++; if ({8'(cyc), cap_dst, cap_m2r, cap_npc} !== {8'd3, 2'b10, 2'b10, 3'd2}) begin errors++;
            $display("FAIL jal_wb cyc=%0d dst=%b m2r=%b npc=%0d exp 3,10,10,2", cyc, cap_dst, cap_m2r, cap_npc); end
        run_instr(6'b000000, 6'b001000, 1'b0, 0);
        checks++; if ({8'(cyc), cap_npc, 4'(n_regwe)} !== {8'd2, 3'd3, 4'd0}) begin errors++;
            $display("FAIL jr_decode cyc=%0d npc=%0d regwe=%0d exp 2,3,0", cyc, cap_npc, n_regwe); end
        exp_ret = (start + 2) % 16;
        checks++; if (retired !== 4'(exp_ret)) begin errors++; $display("FAIL jal_jr_retired got=%0d exp=%0d", retired, exp_ret); end
    endtask

    task automatic test_sw_timeout;
        run_instr(6'b101011, 6'd0, 1'b0, 1000);
        checks++; if ({state, halted, fault_code, mem_req} !== {3'd5, 1'b1, 2'b10, 1'b0}) begin errors++;
            $display("FAIL sw_timeout state=%0d halted=%b fault=%b req=%b exp 5,1,10,0", state, halted, fault_code, mem_req); end
        checks++; if ({4'(n_memreq), 4'(n_pcwe)} !== {4'd4, 4'd0}) begin errors++;
            $display("FAIL sw_timeout_counts req=%0d pcwe=%0d exp 4,0", n_memreq, n_pcwe); end
        checks++; if (retired !== 4'(exp_ret)) begin errors++; $display("FAIL sw_timeout_retired got=%0d exp=%0d", retired, exp_ret); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_ret = 0;
    endtask

    task automatic test_reset_mid_mem;
        op = 6'b101011; func = 6'd0; mem_ready = 1'b0;
        for (int i = 0; i < 10 && state != 3'd3; i++) @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if ({state, mem_req, mem_we} !== {3'd3, 1'b1, 1'b1}) begin errors++;
            $display("FAIL midmem_pre state=%0d req=%b we=%b exp 3,1,1", state, mem_req, mem_we); end
        rst = 1'b0;
        #1;
        checks++; if ({state, mem_req, mem_we, pc_we, reg_we} !== {3'd0, 4'b0000}) begin errors++;
            $display("FAIL midmem_abort state=%0d req=%b we=%b pcwe=%b regwe=%b exp 0,0,0,0,0", state, mem_req, mem_we, pc_we, reg_we); end
        @(negedge clk);
        rst = 1'b1;
        exp_ret = 0;
        checks++; if (retired !== 4'd0) begin errors++; $display("FAIL midmem_retired got=%0d exp=0", retired); end
    endtask

    task automatic test_random;
        int k, w;
        logic z;
        logic [11:0] e;
        logic [5:0] ex;
        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, 9);
            w = $urandom_range(0, 3);
            z = 1'($urandom);
            e = enc(k);
            run_instr(e[11:6], e[5:0], z, w);
            exp_ret = (exp_ret + 1) % 16;
            checks++;
            if ({8'(cyc), 4'(n_pcwe), 4'(n_regwe), 4'(n_irwe), state} !==
                {8'(m_cpi(k, w)), 4'd1, 4'(m_writes(k)), 4'd1, 3'd0}) begin
                errors++;
                $display("FAIL rnd%0d_flow k=%0d w=%0d cyc=%0d pcwe=%0d regwe=%0d irwe=%0d state=%0d exp cyc=%0d pcwe=1 regwe=%0d irwe=1 state=0",
                         n, k, w, cyc, n_pcwe, n_regwe, n_irwe, state, m_cpi(k, w), m_writes(k));
            end
            checks++;
            if ({4'(n_memreq), 4'(n_memwe)} !== {4'((k == K_LW || k == K_SW) ? w + 1 : 0), 4'((k == K_SW) ? w + 1 : 0)}) begin
                errors++; $display("FAIL rnd%0d_mem k=%0d w=%0d req=%0d we=%0d", n, k, w, n_memreq, n_memwe);
            end
            checks++;
            if (cap_npc !== m_npc(k, z)) begin
                errors++; $display("FAIL rnd%0d_npc k=%0d got=%0d exp=%0d", n, k, cap_npc, m_npc(k, z));
            end
            if (m_writes(k)) begin
                checks++;
                if ({cap_dst, cap_m2r} !== m_wbsel(k)) begin
                    errors++; $display("FAIL rnd%0d_wbsel k=%0d got=%b exp=%b", n, k, {cap_dst, cap_m2r}, m_wbsel(k));
                end
            end
            if (k != K_NOP && k != K_JR && k != K_JAL) begin
                ex = m_exec(k);
                checks++;
                if ({cap_alu, cap_src} !== ex[5:1] || (k != K_LUI && cap_ext !== ex[0])) begin
                    errors++; $display("FAIL rnd%0d_exec k=%0d got=%b exp=%b", n, k, {cap_alu, cap_src, cap_ext}, ex);
                end
            end
            checks++;
            if (retired !== 4'(exp_ret)) begin
                errors++; $display("FAIL rnd%0d_retired got=%0d exp=%0d", n, retired, exp_ret);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ori();
        test_beq();
        test_lw();
        test_illegal();
        test_ori();
        test_jal_jr();
        test_sw_timeout();
        test_reset_mid_mem();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
